axi4_read_arbiter: RTL and testbench
====================================

// Module: axi4_read_arbiter
// PURPOSE
//  Round-robin arbiter sharing one AXI4 read master port (AR/R) among NUM_REQ requesters.
//  Grants one full burst at a time; a burst is one AR handshake through the R beat with rlast.
//  Sits between the testbench/traffic agents and the shared axi4_if slave.
//  Drives registered AR fields and routes R beats back to the owning requester.
//  Checks burst length and ID on the way back.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  ADDR_WIDTH  32  araddr width
//  DATA_WIDTH  32  rdata width
//  ID_WIDTH    4   arid/rid width; must be >= $clog2(NUM_REQ)
// PORTS
//  clk          in   1                     system clock, rising edge
//  reset        in   1                     synchronous, active-high
//  req_arvalid  in   NUM_REQ               per-requester AR valid
//  req_araddr   in   NUM_REQ*ADDR_WIDTH    packed; slice i belongs to requester i
//  req_arlen    in   NUM_REQ*8             packed AXI4 arlen (beats-1)
//  req_arready  out  NUM_REQ               per-requester AR accept
//  req_rvalid   out  NUM_REQ               R valid, asserted to the owner only
//  req_rdata    out  DATA_WIDTH            broadcast rdata
//  req_rresp    out  2                     broadcast rresp
//  req_rlast    out  1                     broadcast rlast
//  req_rready   in   NUM_REQ               per-requester R ready
//  m_arvalid    out  1                     shared-port AR valid
//  m_araddr     out  ADDR_WIDTH            registered address
//  m_arlen      out  8                     registered length
//  m_arid       out  ID_WIDTH              zero-extended grant index
//  m_arready    in   1                     shared-port AR ready
//  m_rvalid     in   1                     shared-port R valid
//  m_rdata      in   DATA_WIDTH            shared-port R data
//  m_rresp      in   2                     shared-port R response
//  m_rlast      in   1                     shared-port R last
//  m_rid        in   ID_WIDTH              shared-port R ID
//  m_rready     out  1                     shared-port R ready
//  grant_idx    out  $clog2(NUM_REQ)       current or last owner
//  busy         out  1                     state != IDLE
//  err_len      out  1                     sticky: rlast disagrees with arlen
//  err_id       out  1                     sticky: m_rid != m_arid during DATA
// BEHAVIOUR
//  Reset
//   - All outputs are 0 and state is IDLE.
//   - last_grant = NUM_REQ-1, so requester 0 wins first.
//   - Reset mid-burst abandons the burst; no R routing afterwards.
//  FSM
//   - IDLE: the winner is the first set req_arvalid searched from last_grant+1, wrapping.
//     - req_arready[winner] = 1 in the same cycle (combinational from arvalid).
//     - On that handshake: capture addr/len, set grant_idx, go to ADDR.
//     - No arvalid: stay in IDLE.
//   - ADDR: m_arvalid = 1 with registered fields.
//     - On m_arvalid&m_arready: clear beat_cnt, go to DATA.
//   - DATA: req_rvalid[grant] = m_rvalid; m_rready = req_rready[grant].
//     - Every other req_rvalid bit is 0.
//     - Each R handshake increments beat_cnt (9 bits).
//     - On a handshake with m_rlast: last_grant <= grant, go to IDLE.
//  Timing
//   - Latency is 1 cycle from req AR handshake to m_arvalid.
//   - Minimum 1 IDLE cycle between a burst's last beat and the next grant.
//  Fairness
//   - A requester is skipped only while its arvalid is low.
//   - Wrap-around goes from NUM_REQ-1 to 0.
//  Checks (both errors are sticky until reset)
//   - err_len sets on an R handshake where (m_rlast && beat_cnt != arlen) or (!m_rlast && beat_cnt == arlen).
//   - err_id sets on an R handshake with m_rid != m_arid.
//  Edge cases
//   - m_rvalid in IDLE/ADDR is ignored; m_rready = 0 there.
//   - Changes to req_arvalid after acceptance are ignored, because fields are registered.
// STRUCTURE
//  - axi4_arb_pkg holds:
//    - state_e {IDLE, ADDR, DATA}
//    - AXI_LEN_W = 8
//    - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
//  - Sub-module rr_priority_picker is combinational.
//    - Inputs: req vector and last_grant. Outputs: winner index and any_valid.
// TESTING
//  1. Reset, requester 0 alone with addr 0x100 and len 3.
//     -> req_arready[0] in cycle 0; m_arvalid next cycle with araddr 0x100, arid 0.
//     -> 4 beats reach req_rvalid[0] only; busy drops after rlast.
//  2. All four requesters hold arvalid, single-beat bursts.
//     -> grant order 0,1,2,3,0; no requester is granted twice in a row.
//  3. Backpressure: m_arready low for 5 cycles, then req_rready[g] toggling.
//     -> m_araddr stays stable; beat_cnt counts only handshakes.
//  4. len = 3, slave asserts rlast on beat 2.
//     -> err_len = 1 and returns to IDLE; repeat with correct rlast -> err_len stays 1.
//  5. Slave returns m_rid = 2 while arid = 1.
//     -> err_id = 1; data is still routed to requester 1.
//  6. Reset asserted in DATA mid-burst.
//     -> next cycle all outputs 0, state IDLE, requester 0 has top priority.

Source files
------------

// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 read arbiter.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int unsigned AXI_LEN_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request searched from last_grant+1, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant) + i) % NUM_REQ;
      if (!any_valid && req[IDX_W'(idx)]) begin
        winner    = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master port among NUM_REQ requesters,
// one full burst at a time, with sticky length/ID checks on the returning R channel.
module axi4_read_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_arvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_araddr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0]    req_arlen,
  output logic [NUM_REQ-1:0]              req_arready,
  output logic [NUM_REQ-1:0]              req_rvalid,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic [1:0]                      req_rresp,
  output logic                            req_rlast,
  input  logic [NUM_REQ-1:0]              req_rready,
  output logic                            m_arvalid,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [AXI_LEN_W-1:0]            m_arlen,
  output logic [ID_WIDTH-1:0]             m_arid,
  input  logic                            m_arready,
  input  logic                            m_rvalid,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rlast,
  input  logic [ID_WIDTH-1:0]             m_rid,
  output logic                            m_rready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            busy,
  output logic                            err_len,
  output logic                            err_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [AXI_LEN_W-1:0]   len_q, len_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic                   err_len_q, err_len_d;
  logic                   err_id_q, err_id_d;

  logic [IDX_W-1:0]       winner;
  logic                   any_valid;
  logic                   r_hs;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_arvalid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arid    = ID_WIDTH'(grant_q);
  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);
  assign err_len   = err_len_q;
  assign err_id    = err_id_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    err_len_d    = err_len_q;
    err_id_d     = err_id_q;
    req_arready  = '0;
    req_rvalid   = '0;
    req_rdata    = '0;
    req_rresp    = RESP_OKAY;
    req_rlast    = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    r_hs         = 1'b0;

    case (state_q)
      IDLE: begin
        // arready is suppressed while reset is held so every output reads 0 in reset
        if (any_valid && !reset) begin
          req_arready[winner] = 1'b1;
          addr_d  = req_araddr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = req_arlen[32'(winner)*AXI_LEN_W +: AXI_LEN_W];
          grant_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        req_rvalid[grant_q] = m_rvalid;
        m_rready  = req_rready[grant_q];
        req_rdata = m_rdata;
        req_rresp = m_rresp;
        req_rlast = m_rlast;
        r_hs      = m_rvalid && req_rready[grant_q];
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_rlast != (beat_cnt_q == {1'b0, len_q})) err_len_d = 1'b1;
          if (m_rid != m_arid) err_id_d = 1'b1;
          if (m_rlast) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      err_len_q    <= 1'b0;
      err_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      err_len_q    <= err_len_d;
      err_id_q     <= err_id_d;
    end
  end

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Directed bench for axi4_read_arbiter: grant order, routing, backpressure, error flags, reset.
module tb_axi4_read_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_arvalid;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*8-1:0]   req_arlen;
  logic [NR-1:0]     req_arready;
  logic [NR-1:0]     req_rvalid;
  logic [DW-1:0]     req_rdata;
  logic [1:0]        req_rresp;
  logic              req_rlast;
  logic [NR-1:0]     req_rready;
  logic              m_arvalid;
  logic [AW-1:0]     m_araddr;
  logic [7:0]        m_arlen;
  logic [IW-1:0]     m_arid;
  logic              m_arready;
  logic              m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [IW-1:0]     m_rid;
  logic              m_rready;
  logic [1:0]        grant_idx;
  logic              busy;
  logic              err_len;
  logic              err_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi4_read_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_arvalid (req_arvalid),
    .req_araddr  (req_araddr),
    .req_arlen   (req_arlen),
    .req_arready (req_arready),
    .req_rvalid  (req_rvalid),
    .req_rdata   (req_rdata),
    .req_rresp   (req_rresp),
    .req_rlast   (req_rlast),
    .req_rready  (req_rready),
    .m_arvalid   (m_arvalid),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arid      (m_arid),
    .m_arready   (m_arready),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rid       (m_rid),
    .m_rready    (m_rready),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .err_len     (err_len),
    .err_id      (err_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] addr, input logic [7:0] len);
    req_araddr[r*AW +: AW] = addr;
    req_arlen[r*8 +: 8]    = len;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // From IDLE with req_arvalid already set: expect grant g, then complete the AR handshake.
  task automatic grant_and_addr(input int g, input logic [31:0] exp_addr, input logic [7:0] exp_len);
    logic [NR-1:0] one;
    one = '0;
    one[g] = 1'b1;
    #1;
    check("arready_onehot", 64'(req_arready), 64'(one));
    tick();
    #1;
    check("m_arvalid", 64'(m_arvalid), 64'd1);
    check("m_araddr", 64'(m_araddr), 64'(exp_addr));
    check("m_arlen", 64'(m_arlen), 64'(exp_len));
    check("m_arid", 64'(m_arid), 64'(g));
    check("grant_idx", 64'(grant_idx), 64'(g));
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  // Beats 0..rlast_beat with ready always high; rlast on beat rlast_beat.
  task automatic beats(input int g, input int rlast_beat, input logic [IW-1:0] rid);
    logic [NR-1:0] one;
    one = '0;
    one[g] = 1'b1;
    req_rready = '1;
    for (int b = 0; b <= rlast_beat; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hD000_0000 + 32'(b);
      m_rlast  = (b == rlast_beat);
      m_rid    = rid;
      #1;
      check("rvalid_route", 64'(req_rvalid), 64'(one));
      check("rdata_bcast", 64'(req_rdata), 64'(32'hD000_0000 + 32'(b)));
      check("m_rready", 64'(m_rready), 64'd1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    check("busy_after_last", 64'(busy), 64'd0);
  endtask

  initial begin
    int hs;
    reset = 1'b1; req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    for (int r = 0; r < NR; r++) set_req(r, 32'h1000 * (r + 1), 8'd0);

    // 1: single requester, 4-beat burst
    do_reset();
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_err", 64'({err_len, err_id}), 64'd0);
    check("rst_arready", 64'(req_arready), 64'd0);
    set_req(0, 32'h100, 8'd3);
    req_arvalid = 4'b0001;
    #1;
    check("t1_arready0", 64'(req_arready), 64'h1);
    tick();
    req_arvalid = '0;
    #1;
    check("t1_m_arvalid", 64'(m_arvalid), 64'd1);
    check("t1_m_araddr", 64'(m_araddr), 64'h100);
    check("t1_m_arid", 64'(m_arid), 64'd0);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    beats(0, 3, 4'd0);
    check("t1_err_len", 64'(err_len), 64'd0);

    // 2: all requesters valid, single-beat bursts -> 0,1,2,3,0
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 32'h1000 * (r + 1), 8'd0);
    req_arvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      grant_and_addr(k % 4, 32'h1000 * ((k % 4) + 1), 8'd0);
      beats(k % 4, 0, 4'(k % 4));
    end
    req_arvalid = '0;
    check("t2_err", 64'({err_len, err_id}), 64'd0);

    // 3: AR backpressure then toggling rready on requester 2 (len 2 -> 3 beats)
    do_reset();
    set_req(2, 32'hABC0, 8'd2);
    req_arvalid = 4'b0100;
    #1;
    check("t3_arready2", 64'(req_arready), 64'h4);
    tick();
    req_arvalid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_araddr_hold", 64'(m_araddr), 64'hABC0);
      check("t3_arvalid_hold", 64'(m_arvalid), 64'd1);
      tick();
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    hs = 0;
    m_rid = 4'd2;
    for (int c = 0; c < 6; c++) begin
      m_rvalid = 1'b1;
      m_rlast  = (hs == 2);
      req_rready = (c % 2 == 1) ? 4'b0100 : 4'b0000;
      #1;
      check("t3_rvalid2", 64'(req_rvalid), 64'h4);
      check("t3_m_rready", 64'(m_rready), 64'(c % 2));
      if (c % 2 == 1) hs++;
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; req_rready = '0;
    #1;
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_err_len", 64'(err_len), 64'd0);

    // 4: early rlast (beat index 2 of len 3), then a correct burst; err_len stays set
    do_reset();
    set_req(0, 32'h200, 8'd3);
    req_arvalid = 4'b0001;
    grant_and_addr(0, 32'h200, 8'd3);
    beats(0, 2, 4'd0);
    check("t4_err_len_set", 64'(err_len), 64'd1);
    grant_and_addr(0, 32'h200, 8'd3);
    beats(0, 3, 4'd0);
    req_arvalid = '0;
    check("t4_err_len_sticky", 64'(err_len), 64'd1);
    check("t4_err_id", 64'(err_id), 64'd0);

    // 5: wrong rid on requester 1's burst
    do_reset();
    set_req(1, 32'h300, 8'd1);
    req_arvalid = 4'b0010;
    grant_and_addr(1, 32'h300, 8'd1);
    req_arvalid = '0;
    beats(1, 1, 4'd2);
    check("t5_err_id", 64'(err_id), 64'd1);
    check("t5_err_len", 64'(err_len), 64'd0);

    // 6: requester 2 completes, requester 1 is reset mid-burst; 0 must then win
    do_reset();
    set_req(2, 32'h400, 8'd0);
    req_arvalid = 4'b0100;
    grant_and_addr(2, 32'h400, 8'd0);
    beats(2, 0, 4'd2);
    set_req(1, 32'h500, 8'd3);
    req_arvalid = 4'b0010;
    grant_and_addr(1, 32'h500, 8'd3);
    req_arvalid = '0;
    req_rready = '1;
    m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_rvalid", 64'(req_rvalid), 64'd0);
    check("t6_m_rready", 64'(m_rready), 64'd0);
    check("t6_m_arvalid", 64'(m_arvalid), 64'd0);
    check("t6_grant", 64'(grant_idx), 64'd0);
    reset = 1'b0;
    m_rvalid = 1'b0;
    req_arvalid = 4'b1111;
    #1;
    check("t6_prio0", 64'(req_arready), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
